decode_stage: RTL and testbench

Registered, handshaked instruction decode stage for the RV32 core. Replaces the purely combinational control decode with a single-entry pipeline register. It accepts a full 32-bit instruction word and emits a registered control word plus register indices and immediate. It stalls upstream for a configurable number of cycles after issuing an M-extension multiply, and flags illegal encodings instead of silently emitting defaults.

---
 rtl/decode_stage_pkg.sv | 53 +++++
 rtl/decode_stage_if.sv | 39 +++
 rtl/decode_stage_instr_decode.sv | 116 +++++++++++
 rtl/decode_stage.sv | 131 +++++++++++++
 tb/tb_decode_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, writeback
// select, stage state encoding and the packed control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_MUL   = 4'b0101;
    localparam logic [3:0] ALU_MULH  = 4'b0110;
    localparam logic [3:0] ALU_MULHU = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_SLT   = 4'b1100;
    localparam logic [3:0] ALU_SLTU  = 4'b1101;

    typedef enum logic [1:0] {
        SEL_GPIO = 2'd0,
        SEL_IMMU = 2'd1,
        SEL_ALU  = 2'd2
    } regsel_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_MULWAIT = 2'd2
    } decode_state_t;

    // Control fields carried through the stage register (imm is kept
    // separately because its width follows XLEN).
    typedef struct packed {
        logic       alusrc;
        logic       regwrite;
        regsel_t    regsel;
        logic [3:0] aluop;
        logic       gpio_we;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_word_t;

endpackage

// File: rtl/decode_stage_if.sv
// Upstream/downstream bundle of the decode stage. The stage uses the
// slave modport; the environment (fetch + execute side) uses master.
// Handshake: a word transfers on a rising edge where valid and ready are
// both high; valid must stay high and the word unchanged until then.
interface decode_stage_if #(
    parameter int XLEN = 32
) ();
    import riscv_ctrl_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic            alusrc;
    logic            regwrite;
    logic [1:0]      regsel;
    logic [3:0]      aluop;
    logic            gpio_we;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            busy;
    decode_state_t   dbg_state;

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alusrc, regwrite, regsel, aluop,
               gpio_we, rd, rs1, rs2, imm, illegal, busy, dbg_state
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alusrc, regwrite, regsel, aluop,
               gpio_we, rd, rs1, rs2, imm, illegal, busy, dbg_state
    );
endinterface

// File: rtl/decode_stage_instr_decode.sv
// Combinational RV32 control decode for the supported subset. Anything
// outside the subset is flagged illegal with side-effect-free controls.
module instr_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]     instr,
    output ctrl_word_t      ctrl,
    output logic [XLEN-1:0] imm,
    output logic            is_mul,
    output logic            illegal
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] u_imm;
    logic        bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign u_imm  = {instr[31:12], 12'h000};

    // Field decode; illegal words are scrubbed at the end so they can
    // travel through the pipe without writing any state.
    always_comb begin
        ctrl     = '0;
        ctrl.rd  = instr[11:7];
        ctrl.rs1 = instr[19:15];
        ctrl.rs2 = instr[24:20];
        imm      = XLEN'($signed(instr[31:20]));
        is_mul   = 1'b0;
        bad      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regsel   = SEL_ALU;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  ctrl.aluop = ALU_ADD;
                            3'b001:  ctrl.aluop = ALU_SLL;
                            3'b010:  ctrl.aluop = ALU_SLT;
                            3'b011:  ctrl.aluop = ALU_SLTU;
                            3'b100:  ctrl.aluop = ALU_XOR;
                            3'b101:  ctrl.aluop = ALU_SRL;
                            3'b110:  ctrl.aluop = ALU_OR;
                            default: ctrl.aluop = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        case (funct3)
                            3'b000:  ctrl.aluop = ALU_SUB;
                            3'b101:  ctrl.aluop = ALU_SRA;
                            default: bad = 1'b1;
                        endcase
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            case (funct3)
                                3'b000: begin ctrl.aluop = ALU_MUL;   is_mul = 1'b1; end
                                3'b001: begin ctrl.aluop = ALU_MULH;  is_mul = 1'b1; end
                                3'b011: begin ctrl.aluop = ALU_MULHU; is_mul = 1'b1; end
                                default: bad = 1'b1;
                            endcase
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
            end
            OP_ITYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.regsel   = SEL_ALU;
                case (funct3)
                    3'b000:  ctrl.aluop = ALU_ADD;
                    3'b001:  ctrl.aluop = ALU_SLL;
                    3'b100:  ctrl.aluop = ALU_XOR;
                    3'b110:  ctrl.aluop = ALU_OR;
                    3'b111:  ctrl.aluop = ALU_AND;
                    3'b101:  ctrl.aluop = instr[30] ? ALU_SRA : ALU_SRL;
                    default: bad = 1'b1;
                endcase
            end
            OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.regsel   = SEL_IMMU;
                imm           = XLEN'($signed(u_imm));
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b001) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.gpio_we  = 1'b1;
                    ctrl.regsel   = SEL_GPIO;
                end else begin
                    bad = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl.regwrite = 1'b0;
            ctrl.gpio_we  = 1'b0;
            ctrl.alusrc   = 1'b0;
            ctrl.aluop    = ALU_AND;
            ctrl.regsel   = SEL_GPIO;
            is_mul        = 1'b0;
        end
        illegal = bad;
    end

endmodule

// File: rtl/decode_stage.sv
// Single-entry registered decode stage. Holds one decoded word, passes it
// downstream on a valid/ready handshake, and blocks new input for
// MUL_LATENCY cycles after a multiply leaves the stage.
module decode_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 3,
    parameter bit ENABLE_M    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int             CNT_W      = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY);
    localparam bit             MUL_STALLS = (MUL_LATENCY > 0);

    decode_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic            out_valid_q;
    logic            busy_q;

    ctrl_word_t      ctrl_q;
    logic [XLEN-1:0] imm_q;
    logic            illegal_q;
    logic            held_is_mul;

    ctrl_word_t      dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_is_mul;
    logic            dec_illegal;

    logic            in_ready_c;
    logic            load;

    instr_decode #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr    (bus.instr),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .is_mul   (dec_is_mul),
        .illegal  (dec_illegal)
    );

    // A held multiply never lets a follower in on its handoff cycle; the
    // follower waits out the stall instead.
    assign in_ready_c = (state == ST_EMPTY) ||
                        ((state == ST_FULL) && bus.out_ready && !held_is_mul);
    assign load       = bus.in_valid && in_ready_c;

    // Stage control: occupancy, multiply stall counter, valid and busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_EMPTY;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (bus.in_valid) begin
                        state       <= ST_FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        if (held_is_mul) begin
                            state       <= ST_MULWAIT;
                            cnt         <= CNT_LOAD;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else if (!bus.in_valid) begin
                            state       <= ST_EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                ST_MULWAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        state  <= ST_EMPTY;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    cnt         <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Output word register: changes only when a new instruction is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q      <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
            held_is_mul <= 1'b0;
        end else if (load) begin
            ctrl_q      <= dec_ctrl;
            imm_q       <= dec_imm;
            illegal_q   <= dec_illegal;
            held_is_mul <= dec_is_mul && MUL_STALLS;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.alusrc    = ctrl_q.alusrc;
    assign bus.regwrite  = ctrl_q.regwrite;
    assign bus.regsel    = ctrl_q.regsel;
    assign bus.aluop     = ctrl_q.aluop;
    assign bus.gpio_we   = ctrl_q.gpio_we;
    assign bus.rd        = ctrl_q.rd;
    assign bus.rs1       = ctrl_q.rs1;
    assign bus.rs2       = ctrl_q.rs2;
    assign bus.imm       = imm_q;
    assign bus.illegal   = illegal_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized stream
// checked against a table-driven instruction model and an occupancy model.
module tb_decode_stage;
    import riscv_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus0 ();
    decode_stage_if #(.XLEN(32)) bus1 ();
    decode_stage_if #(.XLEN(32)) bus2 ();

    decode_stage #(.XLEN(32), .MUL_LATENCY(3), .ENABLE_M(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    decode_stage #(.XLEN(32), .MUL_LATENCY(3), .ENABLE_M(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    decode_stage #(.XLEN(32), .MUL_LATENCY(0), .ENABLE_M(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    localparam int LAT0 = 3;

    // ---------------- reference model ----------------
    typedef struct {
        logic       alusrc;
        logic       regwrite;
        logic [1:0] regsel;
        logic [3:0] aluop;
        logic       gpio_we;
        logic       illegal;
        logic       is_mul;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] imm;
    } exp_word_t;

    typedef struct {
        logic [31:0] mask, match;
        logic [3:0]  aluop;
        logic        alusrc, regwrite, gpio_we, is_mul, m_ext;
        logic [1:0]  regsel;
    } rule_t;

    rule_t rules[$];

    task automatic add_rule(input logic [31:0] mask, input logic [31:0] match, input logic [3:0] aluop,
                            input logic alusrc, input logic regwrite, input logic [1:0] regsel,
                            input logic gpio_we, input logic is_mul, input logic m_ext);
        rule_t r;
        r.mask = mask; r.match = match; r.aluop = aluop; r.alusrc = alusrc; r.regwrite = regwrite;
        r.regsel = regsel; r.gpio_we = gpio_we; r.is_mul = is_mul; r.m_ext = m_ext;
        rules.push_back(r);
    endtask

    // Instruction set table: mask/match pairs as in the ISA manual.
    task automatic build_rules();
        add_rule(32'hFE00707F, 32'h00000033, 4'b0011, 0, 1, 2, 0, 0, 0); // add
        add_rule(32'hFE00707F, 32'h00001033, 4'b1000, 0, 1, 2, 0, 0, 0); // sll
        add_rule(32'hFE00707F, 32'h00002033, 4'b1100, 0, 1, 2, 0, 0, 0); // slt
        add_rule(32'hFE00707F, 32'h00003033, 4'b1101, 0, 1, 2, 0, 0, 0); // sltu
        add_rule(32'hFE00707F, 32'h00004033, 4'b0010, 0, 1, 2, 0, 0, 0); // xor
        add_rule(32'hFE00707F, 32'h00005033, 4'b1001, 0, 1, 2, 0, 0, 0); // srl
        add_rule(32'hFE00707F, 32'h00006033, 4'b0001, 0, 1, 2, 0, 0, 0); // or
        add_rule(32'hFE00707F, 32'h00007033, 4'b0000, 0, 1, 2, 0, 0, 0); // and
        add_rule(32'hFE00707F, 32'h40000033, 4'b0100, 0, 1, 2, 0, 0, 0); // sub
        add_rule(32'hFE00707F, 32'h40005033, 4'b1010, 0, 1, 2, 0, 0, 0); // sra
        add_rule(32'hFE00707F, 32'h02000033, 4'b0101, 0, 1, 2, 0, 1, 1); // mul
        add_rule(32'hFE00707F, 32'h02001033, 4'b0110, 0, 1, 2, 0, 1, 1); // mulh
        add_rule(32'hFE00707F, 32'h02003033, 4'b0111, 0, 1, 2, 0, 1, 1); // mulhu
        add_rule(32'h0000707F, 32'h00000013, 4'b0011, 1, 1, 2, 0, 0, 0); // addi
        add_rule(32'h0000707F, 32'h00001013, 4'b1000, 1, 1, 2, 0, 0, 0); // slli
        add_rule(32'h0000707F, 32'h00004013, 4'b0010, 1, 1, 2, 0, 0, 0); // xori
        add_rule(32'h0000707F, 32'h00006013, 4'b0001, 1, 1, 2, 0, 0, 0); // ori
        add_rule(32'h0000707F, 32'h00007013, 4'b0000, 1, 1, 2, 0, 0, 0); // andi
        add_rule(32'h4000707F, 32'h00005013, 4'b1001, 1, 1, 2, 0, 0, 0); // srli
        add_rule(32'h4000707F, 32'h40005013, 4'b1010, 1, 1, 2, 0, 0, 0); // srai
        add_rule(32'h0000007F, 32'h00000037, 4'b0000, 0, 1, 1, 0, 0, 0); // lui
        add_rule(32'h0000707F, 32'h00001073, 4'b0000, 0, 1, 0, 1, 0, 0); // csrrw
    endtask

    function automatic exp_word_t ref_decode(input logic [31:0] ins, input bit enable_m);
        exp_word_t e;
        e.alusrc = 0; e.regwrite = 0; e.regsel = 0; e.aluop = 0; e.gpio_we = 0;
        e.illegal = 1; e.is_mul = 0;
        e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        e.imm = (ins[6:0] == 7'h37) ? {ins[31:12], 12'h000} : {{20{ins[31]}}, ins[31:20]};
        foreach (rules[i]) begin
            if (((ins & rules[i].mask) == rules[i].match) && (!rules[i].m_ext || enable_m)) begin
                e.alusrc = rules[i].alusrc; e.regwrite = rules[i].regwrite; e.regsel = rules[i].regsel;
                e.aluop = rules[i].aluop; e.gpio_we = rules[i].gpio_we; e.is_mul = rules[i].is_mul;
                e.illegal = 0;
            end
        end
        return e;
    endfunction

    function automatic logic [56:0] pack_exp(input exp_word_t e);
        return {e.alusrc, e.regwrite, e.regsel, e.aluop, e.gpio_we, e.illegal, e.rd, e.rs1, e.rs2, e.imm};
    endfunction

    function automatic logic [56:0] dut0_word();
        return {bus0.alusrc, bus0.regwrite, bus0.regsel, bus0.aluop, bus0.gpio_we, bus0.illegal,
                bus0.rd, bus0.rs1, bus0.rs2, bus0.imm};
    endfunction

    // Occupancy model for dut0: holds a word or counts down a stall.
    bit        m_valid;
    int        m_stall;
    exp_word_t m_word;

    task automatic model_reset();
        m_valid = 0;
        m_stall = 0;
        m_word = ref_decode(32'h0, 1'b1);
        m_word.illegal = 0; m_word.rd = 0; m_word.rs1 = 0; m_word.rs2 = 0; m_word.imm = 0;
    endtask

    function automatic bit model_in_ready(input logic ordy);
        return (!m_valid && m_stall == 0) || (m_valid && ordy && !m_word.is_mul);
    endfunction

    task automatic model_step(input logic iv, input logic [31:0] ins, input logic ordy);
        bit rdy;
        bit handoff;
        rdy = model_in_ready(ordy);
        handoff = m_valid && ordy;
        if (m_stall > 0) m_stall--;
        else if (handoff && m_word.is_mul) begin m_valid = 0; m_stall = LAT0; end
        else if (iv && rdy) begin m_valid = 1; m_word = ref_decode(ins, 1'b1); end
        else if (handoff) m_valid = 0;
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd);
        return {im, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0] rd  = 5'($urandom);
        logic [4:0] rs1 = 5'($urandom);
        logic [4:0] rs2 = 5'($urandom);
        logic [2:0] f3  = 3'($urandom);
        case ($urandom_range(0, 8))
            0, 1:    return enc_r(7'h00, rs2, rs1, f3, rd);
            2:       return enc_r(7'h20, rs2, rs1, ($urandom_range(0, 1) == 1) ? 3'b101 : f3, rd);
            3:       return enc_r(7'h01, rs2, rs1, f3, rd);
            4, 5:    return enc_i(12'($urandom), rs1, f3, rd, 7'b0010011);
            6:       return enc_u(20'($urandom), rd);
            7:       return enc_i(12'($urandom), rs1, ($urandom_range(0, 1) == 1) ? 3'b001 : f3, rd, 7'b1110011);
            default: return $urandom();
        endcase
    endfunction

    task automatic drive0(input logic iv, input logic [31:0] ins, input logic ordy);
        bus0.in_valid = iv; bus0.instr = ins; bus0.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(bus0.in_valid, bus0.instr, bus0.out_ready);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] add_i = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        logic [31:0] sub_i = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
        logic [31:0] lui_i = enc_u(20'h12345, 5'd1);
        drive0(1, add_i, 0);
        step();
        n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b want 1", bus0.out_valid); end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus0.out_valid); end
        n_cmp++; if (dut0_word() !== 57'h0) begin n_err++; $display("FAIL reset_word: got %h want 0", dut0_word()); end
        n_cmp++; if (bus0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
        n_cmp++; if (bus0.dbg_state !== ST_EMPTY) begin n_err++; $display("FAIL reset_state: got %0d want EMPTY", bus0.dbg_state); end
        drive0(0, 32'h0, 0);
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus0.in_ready); end
        drive0(1, add_i, 1);
        step();
        n_cmp++; if ({bus0.out_valid, bus0.aluop} !== {1'b1, 4'b0011}) begin n_err++; $display("FAIL stream_add: got %b/%b want 1/0011", bus0.out_valid, bus0.aluop); end
        drive0(1, sub_i, 1);
        step();
        n_cmp++; if ({bus0.out_valid, bus0.aluop} !== {1'b1, 4'b0100}) begin n_err++; $display("FAIL stream_sub: got %b/%b want 1/0100", bus0.out_valid, bus0.aluop); end
        drive0(1, lui_i, 1);
        step();
        n_cmp++; if ({bus0.out_valid, bus0.regsel, bus0.regwrite} !== {1'b1, 2'd1, 1'b1}) begin n_err++; $display("FAIL stream_lui_ctrl: got %b/%0d/%b want 1/1/1", bus0.out_valid, bus0.regsel, bus0.regwrite); end
        n_cmp++; if (bus0.imm !== 32'h12345000) begin n_err++; $display("FAIL stream_lui_imm: got %h want 12345000", bus0.imm); end
        drive0(0, 32'h0, 1);
        step();
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_backpressure();
        logic [56:0] snap;
        logic [31:0] sub_i = enc_r(7'h20, 5'd7, 5'd6, 3'b000, 5'd9);
        drive0(1, enc_r(7'h00, 5'd11, 5'd10, 3'b000, 5'd5), 0);
        step();
        snap = dut0_word();
        n_cmp++; if (snap !== pack_exp(m_word)) begin n_err++; $display("FAIL bp_load: got %h want %h", snap, pack_exp(m_word)); end
        drive0(1, sub_i, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (bus0.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus0.in_ready); end
            n_cmp++; if ({bus0.out_valid, dut0_word()} !== {1'b1, snap}) begin n_err++; $display("FAIL bp_frozen[%0d]: got %b/%h want 1/%h", i, bus0.out_valid, dut0_word(), snap); end
            step();
        end
        bus0.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", bus0.in_ready); end
        step();
        n_cmp++; if (dut0_word() !== pack_exp(ref_decode(sub_i, 1'b1))) begin n_err++; $display("FAIL bp_next_word: got %h want %h", dut0_word(), pack_exp(ref_decode(sub_i, 1'b1))); end
        drive0(0, 32'h0, 1);
        step();
    endtask

    task automatic test_mul_stall();
        int busy_cycles = 0;
        drive0(1, enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3), 1);
        step();
        n_cmp++; if ({bus0.out_valid, bus0.aluop} !== {1'b1, 4'b0101}) begin n_err++; $display("FAIL mul_held: got %b/%b want 1/0101", bus0.out_valid, bus0.aluop); end
        drive0(1, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4), 1);
        #1;
        n_cmp++; if (bus0.in_ready !== 1'b0) begin n_err++; $display("FAIL mul_handoff_ready: got %b want 0", bus0.in_ready); end
        step();
        for (int i = 0; i < 10 && bus0.busy === 1'b1; i++) begin
            n_cmp++; if ({bus0.in_ready, bus0.out_valid} !== 2'b00) begin n_err++; $display("FAIL mul_wait[%0d]: got ready/valid %b%b want 00", i, bus0.in_ready, bus0.out_valid); end
            busy_cycles++;
            step();
        end
        n_cmp++; if (busy_cycles != 3) begin n_err++; $display("FAIL mul_busy_len: got %0d want 3", busy_cycles); end
        n_cmp++; if (bus0.in_ready !== 1'b1) begin n_err++; $display("FAIL mul_ready_after: got %b want 1", bus0.in_ready); end
        step();
        n_cmp++; if ({bus0.out_valid, bus0.aluop, bus0.rd} !== {1'b1, 4'b0011, 5'd4}) begin n_err++; $display("FAIL mul_follower: got %b/%b/%0d want 1/0011/4", bus0.out_valid, bus0.aluop, bus0.rd); end
        drive0(0, 32'h0, 1);
        step();
    endtask

    task automatic test_shift_imm();
        drive0(1, enc_i({7'h20, 5'd3}, 5'd2, 3'b101, 5'd2, 7'b0010011), 1);
        step();
        n_cmp++; if ({bus0.aluop, bus0.alusrc, bus0.regwrite} !== {4'b1010, 1'b1, 1'b1}) begin n_err++; $display("FAIL srai: got %b/%b/%b want 1010/1/1", bus0.aluop, bus0.alusrc, bus0.regwrite); end
        drive0(1, enc_i(12'd3, 5'd2, 3'b101, 5'd2, 7'b0010011), 1);
        step();
        n_cmp++; if ({bus0.aluop, bus0.imm} !== {4'b1001, 32'd3}) begin n_err++; $display("FAIL srli: got %b/%h want 1001/3", bus0.aluop, bus0.imm); end
        drive0(0, 32'h0, 1);
        step();
        // ENABLE_M=0 instance: mulh is illegal and causes no stall.
        bus1.in_valid = 1; bus1.instr = enc_r(7'h01, 5'd2, 5'd1, 3'b001, 5'd3); bus1.out_ready = 1;
        step();
        n_cmp++; if ({bus1.out_valid, bus1.illegal, bus1.regwrite, bus1.aluop} !== {1'b1, 1'b1, 1'b0, 4'b0000}) begin n_err++; $display("FAIL nom_mulh: got %b/%b/%b/%b want 1/1/0/0000", bus1.out_valid, bus1.illegal, bus1.regwrite, bus1.aluop); end
        bus1.instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        #1;
        n_cmp++; if (bus1.in_ready !== 1'b1) begin n_err++; $display("FAIL nom_no_stall: got %b want 1", bus1.in_ready); end
        step();
        n_cmp++; if ({bus1.busy, bus1.illegal, bus1.aluop} !== {1'b0, 1'b0, 4'b0011}) begin n_err++; $display("FAIL nom_follower: got %b/%b/%b want 0/0/0011", bus1.busy, bus1.illegal, bus1.aluop); end
        bus1.in_valid = 0;
        step();
        // MUL_LATENCY=0 instance: multiply streams like any other op.
        bus2.in_valid = 1; bus2.instr = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3); bus2.out_ready = 1;
        step();
        n_cmp++; if ({bus2.out_valid, bus2.aluop} !== {1'b1, 4'b0101}) begin n_err++; $display("FAIL lat0_mul: got %b/%b want 1/0101", bus2.out_valid, bus2.aluop); end
        bus2.instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd8);
        #1;
        n_cmp++; if (bus2.in_ready !== 1'b1) begin n_err++; $display("FAIL lat0_ready: got %b want 1", bus2.in_ready); end
        step();
        n_cmp++; if ({bus2.busy, bus2.out_valid, bus2.aluop, bus2.rd} !== {1'b0, 1'b1, 4'b0011, 5'd8}) begin n_err++; $display("FAIL lat0_follower: got %b/%b/%b/%0d want 0/1/0011/8", bus2.busy, bus2.out_valid, bus2.aluop, bus2.rd); end
        bus2.in_valid = 0;
        step();
    endtask

    task automatic test_csr_illegal();
        logic [31:0] bad_i = $urandom() & 32'hFFFF_FF80;
        drive0(1, enc_i(12'h7C0, 5'd6, 3'b001, 5'd5, 7'b1110011), 1);
        step();
        n_cmp++; if ({bus0.gpio_we, bus0.regwrite, bus0.regsel, bus0.illegal} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin n_err++; $display("FAIL csrrw: got %b/%b/%0d/%b want 1/1/0/0", bus0.gpio_we, bus0.regwrite, bus0.regsel, bus0.illegal); end
        drive0(1, bad_i, 1);
        step();
        n_cmp++; if ({bus0.out_valid, bus0.illegal, bus0.regwrite, bus0.gpio_we, bus0.aluop} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'b0000}) begin n_err++; $display("FAIL illegal_op: got %b/%b/%b/%b/%b want 1/1/0/0/0000", bus0.out_valid, bus0.illegal, bus0.regwrite, bus0.gpio_we, bus0.aluop); end
        drive0(0, 32'h0, 1);
        step();
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL illegal_handoff: got %b want 0", bus0.out_valid); end
        // Reset pulsed while the multiply stall is running.
        drive0(1, enc_r(7'h01, 5'd2, 5'd1, 3'b011, 5'd3), 1);
        step();
        drive0(0, 32'h0, 1);
        step();
        n_cmp++; if (bus0.busy !== 1'b1) begin n_err++; $display("FAIL rst_mw_busy_before: got %b want 1", bus0.busy); end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if ({bus0.busy, bus0.out_valid, bus0.dbg_state} !== {1'b0, 1'b0, ST_EMPTY}) begin n_err++; $display("FAIL rst_mw_abort: got %b/%b/%0d want 0/0/EMPTY", bus0.busy, bus0.out_valid, bus0.dbg_state); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if ({bus0.in_ready, bus0.busy} !== 2'b10) begin n_err++; $display("FAIL rst_mw_after: got %b%b want 10", bus0.in_ready, bus0.busy); end
    endtask

    task automatic test_random();
        bit pend = 0;
        for (int c = 0; c < 400; c++) begin
            n_cmp++; if (bus0.out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, bus0.out_valid, m_valid); end
            n_cmp++; if (bus0.busy !== (m_stall > 0)) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, bus0.busy, (m_stall > 0)); end
            n_cmp++; if (dut0_word() !== pack_exp(m_word)) begin n_err++; $display("FAIL rnd_word[%0d]: got %h want %h", c, dut0_word(), pack_exp(m_word)); end
            if (!pend) begin
                bus0.in_valid = ($urandom_range(0, 9) < 7);
                bus0.instr = gen_instr();
            end
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++; if (bus0.in_ready !== model_in_ready(bus0.out_ready)) begin n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, bus0.in_ready, model_in_ready(bus0.out_ready)); end
            pend = bus0.in_valid && !model_in_ready(bus0.out_ready);
            step();
        end
        drive0(0, 32'h0, 1);
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_rules();
        model_reset();
        drive0(0, 32'h0, 0);
        bus1.in_valid = 0; bus1.instr = 32'h0; bus1.out_ready = 1;
        bus2.in_valid = 0; bus2.instr = 32'h0; bus2.out_ready = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_backpressure();
        test_mul_stall();
        test_shift_imm();
        test_csr_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
